lcd_cgram_loader: RTL and testbench

- Downstream consumer of the 64x8 custom font ROM (8 glyphs x 8 rows, 5-bit pixel rows in bits [4:0]).
- On `start`, issues "Set CGRAM address 0" (0x40) to an HD44780-style 8-bit character LCD, then streams ROM rows 0..8*NUM_GLYPHS-1 as data writes.
- Generates the LCD RS/RW/EN/DB bus timing.
- Sits between the font ROM and the LCD pin drivers; the display-text writer starts once `done` is high.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_write_strobe.sv | 106 ++++++++++
 rtl/lcd_cgram_loader.sv | 121 ++++++++++++
 tb/tb_lcd_cgram_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state type and helpers for the HD44780-style LCD front end.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_CGRAM = 8'h40;
  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;

  // Font ROM rows carry 5 pixel bits in [4:0].
  localparam int ROW_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    EXEC,
    DONE
  } lcd_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: latches RS/DB on an accepted request, then runs SETUP/PULSE/EXEC
// timing on EN. Back-to-back requests are accepted in the last EXEC cycle with no gap.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 12,
  parameter int EXEC_CYC  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic [7:0] i_db,
  output logic       o_ack,
  output logic       o_pulse_end,
  output logic       o_wr_end,
  output logic       o_rs,
  output logic       o_en,
  output logic [7:0] o_db
);

  localparam int CNT_MAX = max3(SETUP_CYC, PULSE_CYC, EXEC_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);

  lcd_state_t       r_state;
  lcd_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rs;
  logic             r_en;
  logic [7:0]       r_db;
  logic             w_ack;
  logic             w_pulse_end;
  logic             w_wr_end;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_ack       = 1'b0;
    w_pulse_end = (r_state == PULSE) && (r_cnt == PULSE_LAST);
    w_wr_end    = (r_state == EXEC) && (r_cnt == EXEC_LAST);

    case (r_state)
      SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_nxt = PULSE;
          w_cnt_nxt   = '0;
        end
      end
      PULSE: begin
        if (w_pulse_end) begin
          w_state_nxt = EXEC;
          w_cnt_nxt   = '0;
        end
      end
      EXEC: begin
        if (w_wr_end) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A new write may start from idle or overlap the final EXEC cycle.
    if (i_req && ((r_state == IDLE) || w_wr_end)) begin
      w_ack       = 1'b1;
      w_state_nxt = SETUP;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_db    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_state_nxt == PULSE);
      if (w_ack) begin
        r_rs <= i_rs;
        r_db <= i_db;
      end
    end
  end

  assign o_ack       = w_ack;
  assign o_pulse_end = w_pulse_end;
  assign o_wr_end    = w_wr_end;
  assign o_rs        = r_rs;
  assign o_en        = r_en;
  assign o_db        = r_db;

endmodule

// File: rtl/lcd_cgram_loader.sv
// Loads 8*NUM_GLYPHS font ROM rows into LCD CGRAM after a Set-CGRAM-address-0 command.
// Optional macro CGLOAD_DDRAM_HOME_EN appends a Set-DDRAM-address-0 command before done.
module lcd_cgram_loader
  import lcd_pkg::*;
#(
  parameter int NUM_GLYPHS = 8,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 12,
  parameter int EXEC_CYC   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [5:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_db,
  output logic       busy,
  output logic       done
);

  localparam int DATA_WRITES = 8 * NUM_GLYPHS;
`ifdef CGLOAD_DDRAM_HOME_EN
  localparam int TOTAL_WRITES = DATA_WRITES + 2;
`else
  localparam int TOTAL_WRITES = DATA_WRITES + 1;
`endif
  localparam int WCNT_W = $clog2(TOTAL_WRITES + 1);

  localparam logic [WCNT_W-1:0] WR_TOTAL = WCNT_W'(TOTAL_WRITES);
`ifdef CGLOAD_DDRAM_HOME_EN
  localparam logic [WCNT_W-1:0] WR_HOME  = WCNT_W'(TOTAL_WRITES - 1);
`endif

  logic [WCNT_W-1:0] r_wr_cnt;
  logic [5:0]        r_rom_addr;
  logic              r_busy;
  logic              r_done;
  logic              w_start_acc;
  logic              w_req;
  logic              w_rs;
  logic [7:0]        w_db;
  logic              w_ack;
  logic              w_pulse_end;
  logic              w_wr_end;
  logic              w_strobe_rs;
  logic              w_rom_unused;

  assign w_start_acc  = start && !r_busy;
  assign w_rom_unused = ^rom_data[7:ROW_BITS];

  // r_wr_cnt counts writes already handed to the strobe; it selects what to offer next.
  always_comb begin
    w_req = 1'b0;
    w_rs  = 1'b0;
    w_db  = 8'h00;
    if (w_start_acc) begin
      w_req = 1'b1;
      w_db  = LCD_CMD_SET_CGRAM;
    end else if (r_busy && (r_wr_cnt < WR_TOTAL)) begin
      w_req = 1'b1;
      w_rs  = 1'b1;
      w_db  = 8'(rom_data[ROW_BITS-1:0]);
`ifdef CGLOAD_DDRAM_HOME_EN
      if (r_wr_cnt == WR_HOME) begin
        w_rs = 1'b0;
        w_db = LCD_CMD_SET_DDRAM;
      end
`endif
    end
  end

  lcd_write_strobe #(
    .SETUP_CYC(SETUP_CYC),
    .PULSE_CYC(PULSE_CYC),
    .EXEC_CYC (EXEC_CYC)
  ) u_strobe (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_rs       (w_rs),
    .i_db       (w_db),
    .o_ack      (w_ack),
    .o_pulse_end(w_pulse_end),
    .o_wr_end   (w_wr_end),
    .o_rs       (w_strobe_rs),
    .o_en       (lcd_en),
    .o_db       (lcd_db)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_cnt   <= '0;
      r_rom_addr <= 6'd0;
    end else if (w_start_acc) begin
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_wr_cnt   <= WCNT_W'(1);
      r_rom_addr <= 6'd0;
    end else if (r_busy) begin
      if (w_ack) r_wr_cnt <= r_wr_cnt + WCNT_W'(1);
      // Advancing at end of PULSE gives the ROM the whole EXEC phase to settle.
      if (w_pulse_end && w_strobe_rs) r_rom_addr <= r_rom_addr + 6'd1;
      if (w_wr_end && (r_wr_cnt == WR_TOTAL)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign rom_addr = r_rom_addr;
  assign lcd_rs   = w_strobe_rs;
  assign lcd_rw   = 1'b0;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_lcd_cgram_loader.sv
// Bench for lcd_cgram_loader: randomized font images checked against a write-list model.
module tb_lcd_cgram_loader;

  localparam int NG = 8;
  localparam int SC = 1;
  localparam int PC = 2;
  localparam int EC = 3;
  localparam int W  = SC + PC + EC;
`ifdef CGLOAD_DDRAM_HOME_EN
  localparam int HOME = 1;
`else
  localparam int HOME = 0;
`endif
  localparam int NWR8 = 1 + 8 * NG + HOME;
  localparam int NWR1 = 1 + 8 + HOME;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] addr8, addr1;
  logic [7:0] data8, data1, db8, db1;
  logic rs8, rw8, en8, busy8, done8;
  logic rs1, rw1, en1, busy1, done1;
  logic [7:0] rom8 [64];
  logic [7:0] rom1 [64];

  assign data8 = rom8[addr8];
  assign data1 = rom1[addr1];

  lcd_cgram_loader #(.NUM_GLYPHS(NG), .SETUP_CYC(SC), .PULSE_CYC(PC), .EXEC_CYC(EC)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .rom_addr(addr8), .rom_data(data8),
    .lcd_rs(rs8), .lcd_rw(rw8), .lcd_en(en8), .lcd_db(db8), .busy(busy8), .done(done8));

  lcd_cgram_loader #(.NUM_GLYPHS(1), .SETUP_CYC(SC), .PULSE_CYC(PC), .EXEC_CYC(EC)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rom_addr(addr1), .rom_data(data1),
    .lcd_rs(rs1), .lcd_rw(rw1), .lcd_en(en1), .lcd_db(db1), .busy(busy1), .done(done1));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  logic [8:0] exp_wr[$];
  logic [8:0] got_wr[$];
  int got_w[$];
  logic prev8 = 1'b0;
  logic prev1 = 1'b0;
  int curw8 = 0;
  int rise1 = 0;
  logic [7:0] font0 [8] = '{8'h0C, 8'h0C, 8'h00, 8'h01, 8'h10, 8'h18, 8'h06, 8'h03};

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: one record {rs,db} per EN rising edge, plus EN high width.
  always @(negedge clk) begin
    if (en8 === 1'b1 && prev8 === 1'b0) begin
      got_wr.push_back({rs8, db8});
      curw8 <= 1;
    end else if (en8 === 1'b1) begin
      curw8 <= curw8 + 1;
    end
    if (en8 === 1'b0 && prev8 === 1'b1) got_w.push_back(curw8);
    prev8 <= en8;
    if (en1 === 1'b1 && prev1 === 1'b0) rise1 <= rise1 + 1;
    prev1 <= en1;
  end

  // Reference: command 0x40, then row k masked to 5 bits, then optional home command.
  task automatic build_exp();
    exp_wr.delete();
    exp_wr.push_back({1'b0, 8'h40});
    for (int k = 0; k < 8 * NG; k++) exp_wr.push_back({1'b1, rom8[k] & 8'h1F});
    if (HOME != 0) exp_wr.push_back({1'b0, 8'h80});
  endtask

  task automatic clear_mon();
    got_wr.delete();
    got_w.delete();
  endtask

  task automatic start_dut8();
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int dt);
    dt = -1;
    for (int i = 0; i < NWR8 * W + 100; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        dt = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (addr8 !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr got %h want 00", addr8); end
    n_cmp++; if (rs8 !== 1'b0) begin n_fail++; $display("FAIL reset_rs got %b want 0", rs8); end
    n_cmp++; if (rw8 !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b want 0", rw8); end
    n_cmp++; if (en8 !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", en8); end
    n_cmp++; if (db8 !== 8'h00) begin n_fail++; $display("FAIL reset_db got %h want 00", db8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int dt;
    for (int i = 0; i < 64; i++) rom8[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) rom8[i] = font0[i];
    build_exp();
    clear_mon();
    start_dut8();
    n_cmp++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL nom_busy_after_start got %b want 1", busy8); end
    wait_done8(dt);
    n_cmp++; if (dt !== NWR8 * W) begin n_fail++; $display("FAIL nom_done_latency got %0d want %0d", dt, NWR8 * W); end
    n_cmp++; if (got_wr.size() !== NWR8) begin n_fail++; $display("FAIL nom_write_count got %0d want %0d", got_wr.size(), NWR8); end
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++;
      if (got_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL nom_write[%0d] got rs/db %h want %h", i, got_wr[i], exp_wr[i]); end
    end
    for (int i = 0; i < got_w.size(); i++) begin
      n_cmp++;
      if (got_w[i] !== PC) begin n_fail++; $display("FAIL nom_en_width[%0d] got %0d want %0d", i, got_w[i], PC); end
    end
    n_cmp++; if (got_wr.size() < 1 || got_wr[0] !== 9'h040) begin n_fail++; $display("FAIL nom_first_cmd got %h want 040", (got_wr.size() > 0) ? got_wr[0] : 9'h1FF); end
    for (int i = 1; i <= 8 && i < got_wr.size(); i++) begin
      n_cmp++;
      if (got_wr[i] !== {1'b1, font0[i-1]}) begin n_fail++; $display("FAIL nom_glyph0_row%0d got %h want %h", i - 1, got_wr[i], {1'b1, font0[i-1]}); end
    end
    n_cmp++; if (addr8 !== 6'd0) begin n_fail++; $display("FAIL nom_rom_addr_wrap got %h want 00", addr8); end
    n_cmp++; if (busy8 !== 1'b0 || en8 !== 1'b0) begin n_fail++; $display("FAIL nom_idle_after_done got busy=%b en=%b want 0/0", busy8, en8); end
  endtask

  task automatic test_restart_ignored();
    int dt;
    for (int i = 0; i < 64; i++) rom8[i] = 8'($urandom);
    build_exp();
    clear_mon();
    start_dut8();
    for (int i = 0; i < 20 * W && got_wr.size() < 10; i++) begin @(negedge clk); #1; end
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    wait_done8(dt);
    n_cmp++; if (dt !== NWR8 * W) begin n_fail++; $display("FAIL restart_done_latency got %0d want %0d", dt, NWR8 * W); end
    n_cmp++; if (got_wr.size() !== NWR8) begin n_fail++; $display("FAIL restart_write_count got %0d want %0d", got_wr.size(), NWR8); end
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++;
      if (got_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL restart_write[%0d] got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_done_restart();
    int dt;
    logic [8:0] prev_seq[$];
    prev_seq = got_wr;
    clear_mon();
    start_dut8();
    @(negedge clk);
    n_cmp++; if (done8 !== 1'b0 || busy8 !== 1'b1) begin n_fail++; $display("FAIL reload_flags got done=%b busy=%b want 0/1", done8, busy8); end
    wait_done8(dt);
    n_cmp++; if (dt !== NWR8 * W) begin n_fail++; $display("FAIL reload_done_latency got %0d want %0d", dt, NWR8 * W); end
    n_cmp++; if (got_wr.size() !== NWR8) begin n_fail++; $display("FAIL reload_write_count got %0d want %0d", got_wr.size(), NWR8); end
    for (int i = 0; i < got_wr.size() && i < prev_seq.size(); i++) begin
      n_cmp++;
      if (got_wr[i] !== exp_wr[i]) begin n_fail++; $display("FAIL reload_write[%0d] got %h want %h", i, got_wr[i], exp_wr[i]); end
    end
  endtask

  task automatic test_mask();
    int dt;
    for (int i = 0; i < 64; i++) rom8[i] = 8'hFF;
    build_exp();
    clear_mon();
    start_dut8();
    wait_done8(dt);
    n_cmp++; if (got_wr.size() !== NWR8) begin n_fail++; $display("FAIL mask_write_count got %0d want %0d", got_wr.size(), NWR8); end
    for (int i = 1; i <= 8 * NG && i < got_wr.size(); i++) begin
      n_cmp++;
      if (got_wr[i] !== 9'h11F) begin n_fail++; $display("FAIL mask_write[%0d] got %h want 11f", i, got_wr[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int sz;
    logic en_seen;
    for (int i = 0; i < 64; i++) rom8[i] = 8'($urandom);
    clear_mon();
    start_dut8();
    for (int i = 0; i < 30 * W && got_wr.size() < 20; i++) begin @(negedge clk); #1; end
    n_cmp++; if (en8 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_pulse got en=%b want 1", en8); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (en8 !== 1'b0) begin n_fail++; $display("FAIL midrst_en got %b want 0", en8); end
    n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0/0", busy8, done8); end
    n_cmp++; if (addr8 !== 6'd0) begin n_fail++; $display("FAIL midrst_rom_addr got %h want 00", addr8); end
    rst = 1'b0;
    sz = got_wr.size();
    en_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (en8 !== 1'b0) en_seen = 1'b1;
    end
    n_cmp++; if (got_wr.size() !== sz || en_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet got %0d extra pulses en_seen=%b want 0/0", got_wr.size() - sz, en_seen); end
  endtask

  task automatic test_one_glyph();
    int dt;
    int t1;
    for (int i = 0; i < 64; i++) rom1[i] = 8'($urandom);
    rise1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    t1 = cyc;
    start1 = 1'b0;
    dt = -1;
    for (int i = 0; i < NWR1 * W + 100; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin
        dt = cyc - t1;
        break;
      end
    end
    n_cmp++; if (dt !== NWR1 * W) begin n_fail++; $display("FAIL ng1_done_latency got %0d want %0d", dt, NWR1 * W); end
    n_cmp++; if (rise1 !== NWR1) begin n_fail++; $display("FAIL ng1_write_count got %0d want %0d", rise1, NWR1); end
    n_cmp++; if (addr1 !== 6'd8) begin n_fail++; $display("FAIL ng1_rom_addr got %0d want 8", addr1); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom8[i] = 8'h00;
      rom1[i] = 8'h00;
    end
    test_reset();
    test_nominal();
    test_restart_ignored();
    test_done_restart();
    test_mask();
    test_reset_mid();
    test_one_glyph();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
